// File: rtl/change_dispenser.sv
// change_dispenser -- returns change for one vending transaction as a stream
// of coins, largest denomination first, drawing on four finite coin stocks.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   start               begin a transaction (only honoured in IDLE)
//   credit, price       16-bit amounts latched on an accepted start
//   refill              reload every stock to INIT_STOCK (only in IDLE)
//   coin_ack            downstream ejector took the presented coin
//   coin_valid          a coin is presented on coin_type
//   coin_type           00=500, 01=1000, 10=2000, 11=5000
//   busy                transaction in progress (SELECT/ISSUE/FINISH)
//   done                one-cycle pulse in FINISH
//   error               last transaction could not be paid out fully
//   change_left         change still owed
//   stock_*             coins held per denomination

// One coin stock: reload on reset/refill, count down on dispense, floor at 0.
module change_dispenser_stock #(
  parameter logic [3:0] INIT = 4'd10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refill,
  input  logic       dec,
  output logic [3:0] count
);
  always_ff @(posedge clk) begin
    if (reset || refill)
      count <= INIT;
    else if (dec && count != 4'd0)
      count <= count - 4'd1;
  end
endmodule

module change_dispenser #(
  parameter logic [3:0] INIT_STOCK = 4'd10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] credit,
  input  logic [15:0] price,
  input  logic        refill,
  input  logic        coin_ack,
  output logic        coin_valid,
  output logic [1:0]  coin_type,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] change_left,
  output logic [3:0]  stock_500,
  output logic [3:0]  stock_1000,
  output logic [3:0]  stock_2000,
  output logic [3:0]  stock_5000
);

  typedef enum logic [1:0] {IDLE, SELECT, ISSUE, FINISH} state_t;

  // Indexed by coin_type code.
  localparam logic [3:0][15:0] COIN_VAL = {16'd5000, 16'd2000, 16'd1000, 16'd500};

  state_t           state, state_n;
  logic [3:0][3:0]  stock;
  logic [3:0]       dec;
  logic             do_refill;
  logic [15:0]      change_n;
  logic [1:0]       type_n;
  logic             error_n;
  logic             found;
  logic [1:0]       pick;

  for (genvar g = 0; g < 4; g++) begin : g_stock
    change_dispenser_stock #(.INIT(INIT_STOCK)) u_stock (
      .clk    (clk),
      .reset  (reset),
      .refill (do_refill),
      .dec    (dec[g]),
      .count  (stock[g])
    );
  end

  assign stock_500  = stock[0];
  assign stock_1000 = stock[1];
  assign stock_2000 = stock[2];
  assign stock_5000 = stock[3];

  // Ascending scan: the last eligible denomination wins, i.e. the largest.
  always_comb begin
    found = 1'b0;
    pick  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (stock[i] != 4'd0 && COIN_VAL[i] <= change_left) begin
        found = 1'b1;
        pick  = i[1:0];
      end
    end
  end

  always_comb begin
    state_n   = state;
    change_n  = change_left;
    type_n    = coin_type;
    error_n   = error;
    dec       = '0;
    do_refill = 1'b0;
    case (state)
      IDLE: begin
        // Refill lands on the same edge as start, so SELECT sees full stocks.
        do_refill = refill;
        if (start) begin
          if (credit < price) begin
            error_n  = 1'b1;
            change_n = '0;
            state_n  = FINISH;
          end else begin
            error_n  = 1'b0;
            change_n = credit - price;
            state_n  = SELECT;
          end
        end
      end
      SELECT: begin
        if (change_left == '0) begin
          state_n = FINISH;
        end else if (found) begin
          type_n  = pick;
          state_n = ISSUE;
        end else begin
          error_n = 1'b1;
          state_n = FINISH;
        end
      end
      ISSUE: begin
        if (coin_ack) begin
          dec[coin_type] = 1'b1;
          change_n       = change_left - COIN_VAL[coin_type];
          state_n        = SELECT;
        end
      end
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      change_left <= '0;
      coin_type   <= 2'd0;
      error       <= 1'b0;
    end else begin
      state       <= state_n;
      change_left <= change_n;
      coin_type   <= type_n;
      error       <= error_n;
    end
  end

  assign coin_valid = (state == ISSUE);
  assign busy       = (state != IDLE);
  assign done       = (state == FINISH);

endmodule
